// File: rtl/riscv_aes_writeback_if.sv
// rtl/riscv_aes_writeback_if.sv - cipher result input, register-file write port and status signals
interface riscv_aes_writeback_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 4
);
    logic                               start_aes_wb_i;
    logic [DATA_WIDTH*NUM_WORDS-1:0]    dataout_i;
    logic [ADDR_WIDTH-1:0]              dest_addr_i;
    logic                               wb_we_o;
    logic [ADDR_WIDTH-1:0]              wb_waddr_o;
    logic [DATA_WIDTH-1:0]              wb_wdata_o;
    logic                               wb_gnt_i;
    logic                               busy_o;
    logic                               done_o;
    logic                               overflow_o;
    logic                               clear_i;

    modport slave (
        input  start_aes_wb_i, dataout_i, dest_addr_i, wb_gnt_i, clear_i,
        output wb_we_o, wb_waddr_o, wb_wdata_o, busy_o, done_o, overflow_o
    );

    modport master (
        output start_aes_wb_i, dataout_i, dest_addr_i, wb_gnt_i, clear_i,
        input  wb_we_o, wb_waddr_o, wb_wdata_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/riscv_aes_writeback.sv
// rtl/riscv_aes_writeback.sv - serialises a cipher result into register-file writes, MSW first
module riscv_aes_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WORDS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_aes_writeback_if.slave    bus
);
    localparam int RES_W = DATA_WIDTH * NUM_WORDS;
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RES_W-1:0]       r_data;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_last;

    assign w_accept = r_we & bus.wb_gnt_i;
    assign w_last   = (r_cnt == LAST_CNT);

    // r_data holds the not-yet-presented words, left-aligned; r_wdata is the word on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.clear_i) begin
                r_ovf <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (bus.start_aes_wb_i) begin
                        r_state <= WRITE;
                        r_cnt   <= '0;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_waddr <= bus.dest_addr_i;
                        r_wdata <= bus.dataout_i[RES_W-1 -: DATA_WIDTH];
                        r_data  <= bus.dataout_i << DATA_WIDTH;
                    end
                end
                WRITE: begin
                    // A dropped result outranks a same-cycle clear.
                    if (bus.start_aes_wb_i) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_we    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_waddr <= r_waddr + ADDR_WIDTH'(1);
                            r_wdata <= r_data[RES_W-1 -: DATA_WIDTH];
                            r_data  <= r_data << DATA_WIDTH;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_we_o    = r_we;
    assign bus.wb_waddr_o = r_waddr;
    assign bus.wb_wdata_o = r_wdata;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.overflow_o = r_ovf;
endmodule

// File: tb/tb_riscv_aes_writeback.sv
// tb/tb_riscv_aes_writeback.sv - self-checking bench for riscv_aes_writeback
module tb_riscv_aes_writeback;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_aes_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) bus ();

    riscv_aes_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] mq_a[$];
    logic [DW-1:0] mq_d[$];
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    bit            m_done = 1'b0;
    bit            m_ovf  = 1'b0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a pending result is simply a queue of (addr, data) words still to be granted.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq_a.delete();
            mq_d.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            bit done_n;
            bit set_n;
            int c;
            c      = cyc;
            cyc    = cyc + 1;
            done_n = 1'b0;
            set_n  = 1'b0;
            if (mq_a.size() > 0) begin
                set_n = bus.start_aes_wb_i;
                if (bus.wb_gnt_i) begin
                    log_a.push_back(mq_a.pop_front());
                    log_d.push_back(mq_d.pop_front());
                    if (mq_a.size() == 0) begin
                        done_n   = 1'b1;
                        done_cyc = c + 1;
                    end
                end
            end else if (bus.start_aes_wb_i) begin
                start_cyc = c;
                for (int k = 0; k < NW; k++) begin
                    mq_a.push_back(AW'(int'(bus.dest_addr_i) + k));
                    mq_d.push_back(DW'(bus.dataout_i >> (DW * (NW - 1 - k))));
                end
            end
            if (set_n) m_ovf = 1'b1;
            else if (bus.clear_i) m_ovf = 1'b0;
            m_done = done_n;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("we", bus.wb_we_o, mq_a.size() > 0);
            chk("busy", bus.busy_o, mq_a.size() > 0);
            chk("done", bus.done_o, m_done);
            chk("overflow", bus.overflow_o, m_ovf);
            if (mq_a.size() > 0) begin
                chk("waddr", bus.wb_waddr_o, mq_a[0]);
                chk("wdata", bus.wb_wdata_o, mq_d[0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [127:0] d, input logic [AW-1:0] a);
        bus.dataout_i      = d;
        bus.dest_addr_i    = a;
        bus.start_aes_wb_i = 1'b1;
        tick();
        bus.start_aes_wb_i = 1'b0;
    endtask

    task automatic drain(input string nm, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.busy_o) busy_cnt++;
            seen = bus.done_o;
            if (!seen) tick();
        end
        chk({nm, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic check_log(input string nm, input logic [AW-1:0] ea [NW], input logic [DW-1:0] ed [NW]);
        chk({nm, "_count"}, log_a.size(), NW);
        if (log_a.size() == NW) begin
            for (int k = 0; k < NW; k++) begin
                chk($sformatf("%s_addr%0d", nm, k), log_a[k], ea[k]);
                chk($sformatf("%s_data%0d", nm, k), log_d[k], ed[k]);
            end
        end
    endtask

    localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] DATA_B = 128'hdeadbeef_deafbabe_cafeface_00000000;

    initial begin
        int bc;
        bus.start_aes_wb_i = 1'b0;
        bus.dataout_i      = '0;
        bus.dest_addr_i    = '0;
        bus.wb_gnt_i       = 1'b0;
        bus.clear_i        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_we", bus.wb_we_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_done", bus.done_o, 1'b0);
        chk("rst_ovf", bus.overflow_o, 1'b0);
        chk("rst_waddr", bus.wb_waddr_o, 5'd0);
        chk("rst_wdata", bus.wb_wdata_o, 32'd0);

        // Basic write, grant always high
        log_a.delete(); log_d.delete();
        bus.wb_gnt_i = 1'b1;
        pulse_start(DATA_A, 5'd10);
        drain("basic", bc);
        chk("basic_busy_cycles", bc, 4);
        chk("basic_done_latency", done_cyc - start_cyc, 5);
        check_log("basic", '{5'd10, 5'd11, 5'd12, 5'd13},
                  '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff});
        tick();

        // Backpressure
        begin
            bit gp [8];
            gp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            log_a.delete(); log_d.delete();
            bus.wb_gnt_i = 1'b0;
            pulse_start(DATA_A, 5'd10);
            for (int i = 0; i < 8; i++) begin
                bus.wb_gnt_i = gp[i];
                tick();
            end
            bus.wb_gnt_i = 1'b1;
            chk("bp_done_now", bus.done_o, 1'b1);
            chk("bp_done_latency", done_cyc - start_cyc, 9);
            check_log("bp", '{5'd10, 5'd11, 5'd12, 5'd13},
                      '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff});
            tick();
        end

        // Address wrap
        log_a.delete(); log_d.delete();
        pulse_start(DATA_A, 5'd30);
        drain("wrap", bc);
        check_log("wrap", '{5'd30, 5'd31, 5'd0, 5'd1},
                  '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff});
        tick();

        // Overflow: second result arrives at cnt=1
        log_a.delete(); log_d.delete();
        pulse_start(DATA_A, 5'd5);
        tick();
        pulse_start(DATA_B, 5'd20);
        drain("ovf", bc);
        check_log("ovf", '{5'd5, 5'd6, 5'd7, 5'd8},
                  '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff});
        chk("ovf_set", bus.overflow_o, 1'b1);
        tick(); tick(); tick();
        chk("ovf_sticky", bus.overflow_o, 1'b1);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        chk("ovf_cleared", bus.overflow_o, 1'b0);

        // Clear together with a dropping start: set wins
        bus.wb_gnt_i = 1'b0;
        pulse_start(DATA_B, 5'd1);
        bus.start_aes_wb_i = 1'b1;
        bus.clear_i        = 1'b1;
        tick();
        bus.start_aes_wb_i = 1'b0;
        bus.clear_i        = 1'b0;
        chk("ovf_set_wins", bus.overflow_o, 1'b1);
        bus.wb_gnt_i = 1'b1;
        drain("ovf2", bc);
        tick();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;

        // Back-to-back: new start in the done cycle
        begin
            bit seen;
            seen = 1'b0;
            pulse_start(DATA_A, 5'd3);
            for (int k = 0; k < 40 && !seen; k++) begin
                seen = bus.done_o;
                if (!seen) tick();
            end
            chk("b2b_done_seen", seen, 1'b1);
            pulse_start(DATA_B, 5'd20);
            chk("b2b_we", bus.wb_we_o, 1'b1);
            chk("b2b_waddr", bus.wb_waddr_o, 5'd20);
            chk("b2b_wdata", bus.wb_wdata_o, 32'hdeadbeef);
            chk("b2b_ovf", bus.overflow_o, 1'b0);
            drain("b2b", bc);
            chk("b2b_ovf_end", bus.overflow_o, 1'b0);
            tick();
        end

        // Reset in WRITE at cnt=2 with overflow set
        log_a.delete(); log_d.delete();
        pulse_start(DATA_A, 5'd12);
        tick();
        bus.start_aes_wb_i = 1'b1;
        tick();
        bus.start_aes_wb_i = 1'b0;
        chk("mid_ovf_before", bus.overflow_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", bus.wb_we_o, 1'b0);
        chk("arst_busy", bus.busy_o, 1'b0);
        chk("arst_ovf", bus.overflow_o, 1'b0);
        chk("arst_waddr", bus.wb_waddr_o, 5'd0);
        chk("arst_wdata", bus.wb_wdata_o, 32'd0);
        chk("arst_done", bus.done_o, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_busy", bus.busy_o, 1'b0);
        chk("post_rst_we", bus.wb_we_o, 1'b0);
        chk("post_rst_writes", log_a.size(), 2);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start_aes_wb_i = ($urandom_range(0, 5) == 0);
            bus.dataout_i      = {$urandom, $urandom, $urandom, $urandom};
            bus.dest_addr_i    = AW'($urandom);
            bus.wb_gnt_i       = ($urandom_range(0, 9) < 7);
            bus.clear_i        = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.start_aes_wb_i = 1'b0;
        bus.clear_i        = 1'b0;
        bus.wb_gnt_i       = 1'b1;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/riscv_aes_writeback.md
Name: riscv_aes_writeback

Overview:
- Downstream stage of riscv_aes_cipher.
- Captures the 128-bit ciphertext when the cipher pulses its completion strobe.
- Serialises the ciphertext into four 32-bit writes on a core register-file write port, using a we/gnt handshake.
- Reports busy, done and overflow status to the issuing pipeline stage.

Parameters:
- DATA_WIDTH, 32, width of one write-port word.
- ADDR_WIDTH, 5, width of the core register-file address.
- NUM_WORDS, 4, words per result; the ciphertext width is DATA_WIDTH*NUM_WORDS.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_aes_wb_i  input  1  one-cycle pulse from the cipher (start_aes_out): result valid.
- dataout_i  input  DATA_WIDTH*NUM_WORDS  cipher result; sampled only on start_aes_wb_i.
- dest_addr_i  input  ADDR_WIDTH  base destination register; sampled with start_aes_wb_i.
- wb_we_o  output  1  write request to the register file.
- wb_waddr_o  output  ADDR_WIDTH  write address.
- wb_wdata_o  output  DATA_WIDTH  write data.
- wb_gnt_i  input  1  register-file grant; a word is accepted when wb_we_o & wb_gnt_i.
- busy_o  output  1  high while a result is held or being written.
- done_o  output  1  one-cycle pulse after the last word is accepted.
- overflow_o  output  1  sticky: a result arrived while the block could not take it.
- clear_i  input  1  synchronous clear of overflow_o.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; word counter cnt=0.
  - Data and address registers are cleared to 0.
  - All outputs are 0.
  - A transfer in progress is abandoned; no further writes are issued.
- States: IDLE, WRITE.
- IDLE:
  - wb_we_o=0 and busy_o=0.
  - On start_aes_wb_i: latch dataout_i and dest_addr_i, set cnt=0, go to WRITE.
- WRITE:
  - wb_we_o=1, busy_o=1.
  - wb_waddr_o = base + cnt, modulo 2^ADDR_WIDTH (base 31 wraps to 0,1,2).
  - wb_wdata_o = word cnt; word 0 = dataout_i[127:96] (MSW, register A), word 3 = dataout_i[31:0].
  - On accept with cnt<NUM_WORDS-1: cnt increments; address and data advance in the next cycle.
  - On accept with cnt=NUM_WORDS-1: go to IDLE; done_o=1 for exactly the following cycle.
  - wb_gnt_i low: hold wb_we_o, wb_waddr_o and wb_wdata_o stable; there is no timeout.
- Latency:
  - start in cycle N puts the first request in cycle N+1.
  - With gnt tied high, the last word is accepted in N+4 and done_o pulses in N+5.
- All outputs are registered; no combinational path from any input to any output.
- wb_gnt_i is ignored whenever wb_we_o=0.
- start_aes_wb_i in WRITE, including the final-accept cycle:
  - The new result is dropped.
  - The held data and address are unchanged.
  - overflow_o is set in the next cycle.
- start_aes_wb_i in the done_o cycle is in IDLE and is accepted normally (back-to-back results).
- overflow_o stays set until clear_i or reset. If clear_i and a dropping start occur in the same cycle, the set wins.
- dataout_i and dest_addr_i changing while in WRITE have no effect.

Test Plan:
- Reset mid-write: raise rst while in WRITE at cnt=2 → all outputs 0 asynchronously; after rst drops, no further writes are issued and busy_o=0.
- Basic write, gnt=1:
  - Stimulus: start with dataout_i=128'h00112233_44556677_8899aabb_ccddeeff, dest_addr_i=10.
  - Required: four consecutive writes, (10,00112233), (11,44556677), (12,8899aabb), (13,ccddeeff).
  - done_o pulses 5 cycles after start; busy_o is high for 4 cycles.
- Backpressure: gnt pattern 0,0,1,0,1,1,0,1 → each word is held stable until granted; same 4 address/data pairs in order; done_o one cycle after the 4th grant.
- Address wrap: dest_addr_i=30 → write addresses 30,31,0,1.
- Overflow:
  - Stimulus: a second start (data 128'hdeadbeef_deafbabe_cafeface_0) arrives while the first result is at cnt=1.
  - Required: the first result is written intact; overflow_o=1 and sticky; clear_i clears it.
  - clear_i together with a new dropping start leaves overflow_o=1.
- Back-to-back: second start in the done_o cycle → the second result's first write appears in the next cycle; overflow_o stays 0.
